// File: rtl/jtdd_pkg.sv
// Shared JTDD ROM layout: file offsets of each ROM region, SDRAM word bases,
// the download request record and the FSM state type.
package jtdd_pkg;

  localparam logic [21:0] BANK_OFFSET   = 22'h000000;
  localparam logic [21:0] MAIN_OFFSET   = 22'h020000;
  localparam logic [21:0] SND_OFFSET    = 22'h028000;
  localparam logic [21:0] ADPCM0_OFFSET = 22'h030000;
  localparam logic [21:0] ADPCM1_OFFSET = 22'h040000;
  localparam logic [21:0] CHAR_OFFSET   = 22'h050000;
  localparam logic [21:0] SCR_OFFSET    = 22'h058000;
  localparam logic [21:0] OBJ_OFFSET    = 22'h098000;
  localparam logic [21:0] PROM_OFFSET   = 22'h118000;
  localparam logic [21:0] SCR_BASE      = 22'h040000;
  localparam logic [21:0] OBJ_BASE      = 22'h080000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic        prom;
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } req_t;

  // 1 = lane masked: the high lane writes with 2'b01, the low lane with 2'b10
  function automatic logic [1:0] lane_mask(input logic hi);
    return hi ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/jtdd_dwnld_map.sv
// Combinational region decode: file byte address to SDRAM word address and lane
// mask, or to a priority PROM address. Zero latency, no flow control.
module jtdd_dwnld_map
  import jtdd_pkg::*;
#(
  parameter logic [21:0] SCR_START  = SCR_OFFSET,
  parameter logic [21:0] OBJ_START  = OBJ_OFFSET,
  parameter logic [21:0] PROM_START = PROM_OFFSET,
  parameter logic [21:0] SCR_ADDR   = SCR_BASE,
  parameter logic [21:0] OBJ_ADDR   = OBJ_BASE
) (
  input  logic [21:0] addr,
  input  logic [7:0]  data,
  output logic        vld,
  output req_t        req
);

  localparam logic [21:0] PROM_END = PROM_START + 22'd256;

  logic [17:0] off_scr;
  logic [18:0] off_obj;
  logic [7:0]  off_prom;

  assign off_scr  = 18'(addr - SCR_START);
  assign off_obj  = 19'(addr - OBJ_START);
  assign off_prom = 8'(addr - PROM_START);

  always_comb begin
    vld      = 1'b0;
    req      = '0;
    req.mask = 2'b11;
    req.data = data;
    if (addr < SCR_START) begin
      vld      = 1'b1;
      req.addr = {1'b0, addr[21:1]};
      req.mask = lane_mask(addr[0]);
    end else if (addr < OBJ_START) begin
      // each graphics region keeps its low plane in the first half, high plane in the second
      vld      = 1'b1;
      req.addr = SCR_ADDR + {5'd0, off_scr[16:0]};
      req.mask = lane_mask(off_scr[17]);
    end else if (addr < PROM_START) begin
      vld      = 1'b1;
      req.addr = OBJ_ADDR + {4'd0, off_obj[17:0]};
      req.mask = lane_mask(off_obj[18]);
    end else if (addr < PROM_END) begin
      vld      = 1'b1;
      req.prom = 1'b1;
      req.addr = {14'd0, off_prom};
    end
  end

endmodule

// File: rtl/jtdd_dwnld.sv
// ROM download router: loader bytes to SDRAM write requests and PROM strobes, 1 cycle
// from strobe to request; prog_we held until sdram_ack, one skid entry, overflow sets ovf.
module jtdd_dwnld
  import jtdd_pkg::*;
#(
  parameter logic [21:0] SCR_START  = SCR_OFFSET,
  parameter logic [21:0] OBJ_START  = OBJ_OFFSET,
  parameter logic [21:0] PROM_START = PROM_OFFSET,
  parameter logic [21:0] SCR_ADDR   = SCR_BASE,
  parameter logic [21:0] OBJ_ADDR   = OBJ_BASE,
  parameter logic [7:0]  TAIL       = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  input  logic        sdram_ack,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  output logic        prom_prio_we,
  output logic        dwnld_busy,
  output logic        ovf
);

  req_t   new_req;
  logic   new_vld;
  logic   strobe;
  state_t state;
  req_t   skid;
  logic   skid_vld;
  logic   dl_q;
  logic   [7:0] tail;
  logic   can_present;
  req_t   nxt;
  logic   nxt_vld;

  jtdd_dwnld_map #(
    .SCR_START  (SCR_START),
    .OBJ_START  (OBJ_START),
    .PROM_START (PROM_START),
    .SCR_ADDR   (SCR_ADDR),
    .OBJ_ADDR   (OBJ_ADDR)
  ) u_map (
    .addr (ioctl_addr),
    .data (ioctl_data),
    .vld  (new_vld),
    .req  (new_req)
  );

  // Bytes past the PROM are not strobes at all: never queued, never flagged
  assign strobe      = downloading & ioctl_wr & new_vld;
  assign can_present = (state == ST_IDLE) | sdram_ack;
  assign nxt         = skid_vld ? skid : new_req;
  assign nxt_vld     = skid_vld | strobe;
  assign dwnld_busy  = downloading | (state == ST_WAIT) | skid_vld | (tail != 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      prog_addr    <= '0;
      prog_data    <= '0;
      prog_mask    <= 2'b11;
      prog_we      <= 1'b0;
      prom_prio_we <= 1'b0;
      skid         <= '0;
      skid_vld     <= 1'b0;
      ovf          <= 1'b0;
      dl_q         <= 1'b0;
      tail         <= '0;
    end else begin
      dl_q         <= downloading;
      prom_prio_we <= 1'b0;
      if (downloading && !dl_q) begin
        tail <= '0;
        ovf  <= 1'b0;
      end else if (!downloading && dl_q) begin
        tail <= TAIL;
      end else if (tail != 8'd0) begin
        tail <= tail - 8'd1;
      end

      if (can_present) begin
        // The skid entry always leaves first; a coincident strobe refills the slot
        if (nxt_vld) begin
          prog_addr    <= nxt.addr;
          prog_data    <= nxt.data;
          prog_mask    <= nxt.mask;
          prog_we      <= ~nxt.prom;
          prom_prio_we <= nxt.prom;
          state        <= nxt.prom ? ST_IDLE : ST_WAIT;
        end else begin
          prog_we <= 1'b0;
          state   <= ST_IDLE;
        end
        skid     <= new_req;
        skid_vld <= skid_vld & strobe;
      end else if (strobe) begin
        if (!skid_vld) begin
          skid     <= new_req;
          skid_vld <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtdd_dwnld.sv
// Self-checking bench for jtdd_dwnld: directed cases then random traffic against a
// queue-based reference model of the download router.
module tb_jtdd_dwnld;

  logic        clk;
  logic        rst;
  logic        downloading;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        sdram_ack;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prom_prio_we;
  logic        dwnld_busy;
  logic        ovf;

  jtdd_dwnld dut (
    .clk          (clk),
    .rst          (rst),
    .downloading  (downloading),
    .ioctl_addr   (ioctl_addr),
    .ioctl_data   (ioctl_data),
    .ioctl_wr     (ioctl_wr),
    .sdram_ack    (sdram_ack),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .prog_mask    (prog_mask),
    .prog_we      (prog_we),
    .prom_prio_we (prom_prio_we),
    .dwnld_busy   (dwnld_busy),
    .ovf          (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit prom;
    int addr;
    int data;
    int mask;
  } m_req_t;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: queue of accepted requests, head is the one on the outputs
  m_req_t q[$];
  bit e_we, e_pulse, e_ovf, dl_prev;
  int e_addr, e_data, e_mask, tail_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit mdl_map(input int a, input int d, output m_req_t r);
    int off;
    r.data = d;
    r.prom = 1'b0;
    r.addr = 0;
    r.mask = 3;
    if (a < 'h58000) begin
      r.addr = a / 2;
      r.mask = (a % 2 == 1) ? 1 : 2;
      return 1'b1;
    end
    if (a < 'h98000) begin
      off = a - 'h58000;
      r.addr = 'h40000 + off % 'h20000;
      r.mask = (off >= 'h20000) ? 1 : 2;
      return 1'b1;
    end
    if (a < 'h118000) begin
      off = a - 'h98000;
      r.addr = 'h80000 + off % 'h40000;
      r.mask = (off >= 'h40000) ? 1 : 2;
      return 1'b1;
    end
    if (a < 'h118100) begin
      r.prom = 1'b1;
      r.addr = a - 'h118000;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    e_we = 0; e_pulse = 0; e_ovf = 0; dl_prev = 0;
    e_addr = 0; e_data = 0; e_mask = 3; tail_m = 0;
  endtask

  task automatic model_step();
    m_req_t r;
    bit hit;
    if (downloading && !dl_prev) begin
      tail_m = 0;
      e_ovf  = 0;
    end else if (!downloading && dl_prev) begin
      tail_m = 255;
    end else if (tail_m != 0) begin
      tail_m--;
    end
    dl_prev = downloading;

    if (e_we && sdram_ack) void'(q.pop_front());
    hit = mdl_map(int'(ioctl_addr), int'(ioctl_data), r);
    if (downloading && ioctl_wr && hit) begin
      if (q.size() < 2) q.push_back(r);
      else e_ovf = 1;
    end

    e_pulse = 0;
    if (q.size() > 0) begin
      e_addr = q[0].addr;
      e_data = q[0].data;
      e_mask = q[0].mask;
      if (q[0].prom) begin
        e_pulse = 1;
        e_we    = 0;
        void'(q.pop_front());
      end else begin
        e_we = 1;
      end
    end else begin
      e_we = 0;
    end
  endtask

  task automatic check_all();
    chk("prog_we", prog_we, e_we);
    chk("prom_prio_we", prom_prio_we, e_pulse);
    chk("prog_addr", prog_addr, e_addr);
    chk("prog_data", prog_data, e_data);
    chk("prog_mask", prog_mask, e_mask);
    chk("ovf", ovf, e_ovf);
    chk("dwnld_busy", dwnld_busy, downloading || q.size() != 0 || tail_m != 0);
  endtask

  task automatic cycle(input bit d, input bit w, input logic [21:0] a,
                       input logic [7:0] dt, input bit ak);
    downloading = d;
    ioctl_wr    = w;
    ioctl_addr  = a;
    ioctl_data  = dt;
    sdram_ack   = ak;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_addr"}, prog_addr, 0);
    chk({tag, "_data"}, prog_data, 0);
    chk({tag, "_mask"}, prog_mask, 2'b11);
    chk({tag, "_we"}, prog_we, 0);
    chk({tag, "_prom_we"}, prom_prio_we, 0);
    chk({tag, "_busy"}, dwnld_busy, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  function automatic logic [21:0] rnd_addr();
    case ($urandom_range(0, 5))
      0: return 22'($urandom_range(0, 'h57FFF));
      1: return 22'($urandom_range('h58000, 'h97FFF));
      2: return 22'($urandom_range('h98000, 'h117FFF));
      3: return 22'($urandom_range('h118000, 'h1180FF));
      4: return 22'($urandom_range('h118100, 'h3FFFFF));
      default: begin
        case ($urandom_range(0, 7))
          0: return 22'h057FFF;
          1: return 22'h058000;
          2: return 22'h097FFF;
          3: return 22'h098000;
          4: return 22'h117FFF;
          5: return 22'h118000;
          6: return 22'h1180FF;
          default: return 22'h118100;
        endcase
      end
    endcase
  endfunction

  initial begin
    bit dl;
    rst = 1'b1; downloading = 0; ioctl_wr = 0; ioctl_addr = 0; ioctl_data = 0; sdram_ack = 0;
    model_reset();
    @(negedge clk);
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);

    // low-region byte, ack three cycles after the strobe
    cycle(1, 1, 22'h020001, 8'hA5, 0);
    chk("main_addr", prog_addr, 22'h010000);
    chk("main_mask", prog_mask, 2'b01);
    chk("main_data", prog_data, 8'hA5);
    chk("main_we1", prog_we, 1);
    cycle(1, 0, 0, 0, 0);
    chk("main_we2", prog_we, 1);
    cycle(1, 0, 0, 0, 0);
    chk("main_we3", prog_we, 1);
    cycle(1, 0, 0, 0, 1);
    chk("main_we_drop", prog_we, 0);

    cycle(1, 1, 22'h078004, 8'h11, 0);
    chk("scr_addr", prog_addr, 22'h040004);
    chk("scr_mask", prog_mask, 2'b01);
    cycle(1, 0, 0, 0, 1);

    cycle(1, 1, 22'h0D8010, 8'h22, 0);
    chk("obj_addr", prog_addr, 22'h080010);
    chk("obj_mask", prog_mask, 2'b01);
    cycle(1, 0, 0, 0, 1);

    cycle(1, 1, 22'h118042, 8'h3C, 0);
    chk("prom_pulse", prom_prio_we, 1);
    chk("prom_addr", prog_addr[7:0], 8'h42);
    chk("prom_data", prog_data, 8'h3C);
    chk("prom_no_we", prog_we, 0);
    cycle(1, 0, 0, 0, 0);
    chk("prom_pulse_end", prom_prio_we, 0);

    // three back-to-back strobes without ack: present, skid, drop
    cycle(1, 1, 22'h000100, 8'h01, 0);
    cycle(1, 1, 22'h000101, 8'h02, 0);
    cycle(1, 1, 22'h000102, 8'h03, 0);
    chk("skid_ovf", ovf, 1);
    chk("skid_head_data", prog_data, 8'h01);
    cycle(1, 0, 0, 0, 1);
    chk("skid_next_we", prog_we, 1);
    chk("skid_next_data", prog_data, 8'h02);
    chk("skid_next_mask", prog_mask, 2'b01);
    cycle(1, 0, 0, 0, 1);
    chk("skid_drain", prog_we, 0);

    // downloading falls with one write pending
    cycle(1, 1, 22'h000040, 8'h77, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    chk("tail_write_done", prog_we, 0);
    for (int i = 0; i < 250; i++) cycle(0, 0, 0, 0, 0);
    chk("tail_busy_hold", dwnld_busy, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    chk("tail_busy_end", dwnld_busy, 0);

    // asynchronous reset in the middle of a pending write
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 22'h058003, 8'h5A, 0);
    cycle(1, 1, 22'h098005, 8'h6B, 0);
    #2 rst = 1'b1; downloading = 0; ioctl_wr = 0;
    #1 check_reset_vals("async_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // random traffic
    dl = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) dl = ~dl;
      cycle(dl, $urandom_range(0, 1) == 1, rnd_addr(), 8'($urandom),
            $urandom_range(0, 9) < 4);
    end
    for (int i = 0; i < 300; i++) cycle(0, 0, 0, 0, 1);
    chk("final_idle_busy", dwnld_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
